// File: rtl/mips_dbg_pkg.sv
// Shared constants for the MIPS host debug sequencer.
//  - Host command bytes.
//  - Sequencer state encoding.
//  - Number of words in a register dump.
// Optional feature macro: DBG_CYCLE_COUNT_EN adds a cycle-count word to the dump.
package mips_dbg_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_CNT   = 3'd1,
    LD_BYTE  = 3'd2,
    LD_WRITE = 3'd3,
    RUN      = 3'd4,
    STEP     = 3'd5,
    DUMP     = 3'd6
  } dbg_state_e;

  localparam int unsigned N_REGS_DEF = 8;

  // PC + registers (+ cycle count when enabled)
  function automatic int unsigned dump_words(input int unsigned n_regs);
`ifdef DBG_CYCLE_COUNT_EN
    return n_regs + 2;
`else
    return n_regs + 1;
`endif
  endfunction

  localparam int unsigned DUMP_WORDS = dump_words(N_REGS_DEF);

endpackage

// File: rtl/mips_debug_ctrl_serializer.sv
// dbg_tx_serializer: captures a snapshot of n_words words and streams it to
// the UART TX one byte at a time, word 0 first, each word LSB byte first.
// Ports:
//  clk, reset   clock, asynchronous active-low reset
//  load         1-cycle strobe: capture snap and start a new dump
//  snap         snapshot, word 0 in the low bits
//  tx_done      UART finished the previous byte (ignored when none is outstanding)
//  tx_data      byte to transmit
//  tx_start     1-cycle strobe: send tx_data
//  done         1-cycle (combinational) pulse on the last byte's tx_done
module dbg_tx_serializer #(
  parameter int unsigned len_data = 32,
  parameter int unsigned len_byte = 8,
  parameter int unsigned n_words  = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [n_words*len_data-1:0]  snap,
  input  logic                         tx_done,
  output logic [len_byte-1:0]          tx_data,
  output logic                         tx_start,
  output logic                         done
);

  localparam int unsigned NB = n_words * len_data / len_byte;
  localparam int unsigned IW = $clog2(NB);

  logic [n_words*len_data-1:0] snap_q, snap_d;
  logic [IW-1:0]               idx_q, idx_d, idx_nxt;
  logic                        pend_q, pend_d;    // first byte to be launched next edge
  logic                        outst_q, outst_d;  // a byte is on the wire
  logic                        tx_start_q, tx_start_d;
  logic [len_byte-1:0]         tx_data_q, tx_data_d;
  logic                        last;

  always_comb begin
    snap_d     = snap_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    outst_d    = outst_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    done       = 1'b0;
    idx_nxt    = idx_q + 1'b1;
    last       = (idx_q == IW'(NB - 1));

    if (load) begin
      snap_d  = snap;
      idx_d   = '0;
      pend_d  = 1'b1;
      outst_d = 1'b0;
    end else if (pend_q) begin
      tx_start_d = 1'b1;
      tx_data_d  = snap_q[len_byte*idx_q +: len_byte];
      outst_d    = 1'b1;
      pend_d     = 1'b0;
    end else if (outst_q && tx_done) begin
      if (last) begin
        outst_d = 1'b0;
        done    = 1'b1;
      end else begin
        idx_d      = idx_nxt;
        tx_start_d = 1'b1;
        tx_data_d  = snap_q[len_byte*idx_nxt +: len_byte];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q     <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      outst_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      outst_q    <= outst_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl: host-facing sequencer for the MIPS pipeline.
//  'L' N w0..wN-1 : load N words (4 bytes each, LSB first) into instruction memory from address 0
//  'C'            : run until halt_flag, then dump PC and registers
//  'S'            : advance one cycle (unless halted), then dump
// Ports:
//  clk, reset                 clock, asynchronous active-low reset
//  rx_data, rx_done           received byte + valid strobe
//  tx_done                    UART finished previous byte
//  halt_flag                  pipeline halted (level)
//  in_pc, in_regs             state to dump (reg0 in low bits)
//  tx_data, tx_start          byte to send + strobe
//  debug_flag                 instruction memory owned by the loader
//  out_addr_mem, out_ins_to_mem, wea_ram_inst   instruction-memory write port
//  cpu_en                     pipeline advance enable
//  busy                       sequencer not idle
// Optional feature macro: DBG_CYCLE_COUNT_EN appends a saturating cpu_en cycle count to the dump.
module mips_debug_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int unsigned len_data = 32,
  parameter int unsigned len_addr = 7,
  parameter int unsigned len_byte = 8,
  parameter int unsigned n_regs   = N_REGS_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [len_byte-1:0]        rx_data,
  input  logic                       rx_done,
  input  logic                       tx_done,
  input  logic                       halt_flag,
  input  logic [len_data-1:0]        in_pc,
  input  logic [n_regs*len_data-1:0] in_regs,
  output logic [len_byte-1:0]        tx_data,
  output logic                       tx_start,
  output logic                       debug_flag,
  output logic [len_addr-1:0]        out_addr_mem,
  output logic [len_data-1:0]        out_ins_to_mem,
  output logic                       wea_ram_inst,
  output logic                       cpu_en,
  output logic                       busy
);

  localparam int unsigned NWORDS = dump_words(n_regs);
  localparam int unsigned SNAP_W = NWORDS * len_data;
  localparam int unsigned BPW    = len_data / len_byte;
  localparam int unsigned BCW    = (BPW > 1) ? $clog2(BPW) : 1;

  dbg_state_e            state_q, state_d;
  logic [len_byte-1:0]   words_left_q, words_left_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [len_data-1:0]   word_q, word_d;
  logic [len_addr-1:0]   addr_q, addr_d;
  logic                  ser_load, ser_done, cmd_start;
  logic [SNAP_W-1:0]     snap;

  // Halt masks cpu_en in the same cycle it is seen.
  assign cpu_en    = ((state_q == RUN) || (state_q == STEP)) && !halt_flag;
  assign cmd_start = (state_q == IDLE) && rx_done &&
                     ((rx_data == CMD_CONT) || (rx_data == CMD_STEP));

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    addr_d       = addr_q;
    ser_load     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_done) begin
          if (rx_data == CMD_LOAD) begin
            state_d = LD_CNT;
            addr_d  = '0;  // every load image starts at address 0
          end else if (rx_data == CMD_CONT) begin
            state_d = RUN;
          end else if (rx_data == CMD_STEP) begin
            state_d = STEP;
          end
        end
      end
      LD_CNT: begin
        if (rx_done) begin
          if (rx_data == '0) begin
            state_d = IDLE;
          end else begin
            words_left_d = rx_data;
            byte_cnt_d   = '0;
            state_d      = LD_BYTE;
          end
        end
      end
      LD_BYTE: begin
        if (rx_done) begin
          // the previous word stays visible until the first byte of the next arrives
          if (byte_cnt_q == '0) begin
            word_d = len_data'(rx_data);
          end else begin
            word_d[len_byte*byte_cnt_q +: len_byte] = rx_data;
          end
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == BCW'(BPW - 1)) begin
            byte_cnt_d = '0;
            state_d    = LD_WRITE;
          end
        end
      end
      LD_WRITE: begin
        addr_d       = addr_q + 1'b1;
        words_left_d = words_left_q - 1'b1;
        state_d      = (words_left_q == len_byte'(1)) ? IDLE : LD_BYTE;
      end
      RUN: begin
        if (halt_flag) begin
          state_d  = DUMP;
          ser_load = 1'b1;
        end
      end
      STEP: begin
        state_d  = DUMP;
        ser_load = 1'b1;
      end
      DUMP: begin
        if (ser_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DBG_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (cmd_start) begin
      cyc_cnt_d = '0;
    end else if (cpu_en && (cyc_cnt_q != '1)) begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_cnt_q <= '0;
    else        cyc_cnt_q <= cyc_cnt_d;
  end

  // the step cycle's own increment lands on the same edge as the snapshot
  assign snap = {len_data'(cyc_cnt_d), in_regs, in_pc};
`else
  assign snap = {in_regs, in_pc};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
    end
  end

  dbg_tx_serializer #(
    .len_data (len_data),
    .len_byte (len_byte),
    .n_words  (NWORDS)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load),
    .snap     (snap),
    .tx_done  (tx_done),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (ser_done)
  );

  assign debug_flag     = (state_q == LD_CNT) || (state_q == LD_BYTE) || (state_q == LD_WRITE);
  assign wea_ram_inst   = (state_q == LD_WRITE);
  assign out_addr_mem   = addr_q;
  assign out_ins_to_mem = word_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Self-checking bench for mips_debug_ctrl: directed command sequence with
// randomized data, checked against a memory-image / byte-stream reference model.
module tb_mips_debug_ctrl;
  import mips_dbg_pkg::*;

`ifdef DBG_CYCLE_COUNT_EN
  localparam int NBYTES = 40;
`else
  localparam int NBYTES = 36;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_done, tx_done, halt_flag;
  logic [31:0]  in_pc;
  logic [255:0] in_regs;
  logic [7:0]   tx_data;
  logic         tx_start, debug_flag, wea_ram_inst, cpu_en, busy;
  logic [6:0]   out_addr_mem;
  logic [31:0]  out_ins_to_mem;

  always #5 clk = ~clk;

  mips_debug_ctrl #(
    .len_data (32),
    .len_addr (7),
    .len_byte (8),
    .n_regs   (8)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .rx_data        (rx_data),
    .rx_done        (rx_done),
    .tx_done        (tx_done),
    .halt_flag      (halt_flag),
    .in_pc          (in_pc),
    .in_regs        (in_regs),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .debug_flag     (debug_flag),
    .out_addr_mem   (out_addr_mem),
    .out_ins_to_mem (out_ins_to_mem),
    .wea_ram_inst   (wea_ram_inst),
    .cpu_en         (cpu_en),
    .busy           (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc = cyc + 1;

  // observation log, sampled mid-cycle
  logic [31:0] dut_mem [128];
  int          wr_cnt = 0;
  int          wr_cyc_q [$];
  int          en_cyc_q [$];
  logic [7:0]  tx_q [$];
  int          txs_cyc_q [$];

  always @(negedge clk) begin
    if (wea_ram_inst === 1'b1) begin
      dut_mem[out_addr_mem] = out_ins_to_mem;
      wr_cnt = wr_cnt + 1;
      wr_cyc_q.push_back(cyc);
    end
    if (cpu_en === 1'b1) en_cyc_q.push_back(cyc);
    if (tx_start === 1'b1) begin
      tx_q.push_back(tx_data);
      txs_cyc_q.push_back(cyc);
    end
  end

  // reference model state
  logic [31:0] exp_mem [128];
  logic [31:0] ld_q [$];
  logic [31:0] m_pc;
  logic [31:0] m_regs [8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_state();
    in_pc = m_pc;
    for (int i = 0; i < 8; i++) in_regs[32*i +: 32] = m_regs[i];
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int c);
    step();
    rx_data = b;
    rx_done = 1'b1;
    c = cyc;
    step();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    repeat (gap) step();
  endtask

  // load the first n words of ld_q and compare the resulting memory image
  task automatic do_load(input int n);
    int c, wr0;
    int last_c [$];
    logic [7:0] nb;
    logic [31:0] w;
    wr0 = wr_cnt;
    wr_cyc_q.delete();
    nb = n[7:0];
    send_byte(CMD_LOAD, 1, c);
    check("debug_flag_in_load", debug_flag, 1);
    send_byte(nb, $urandom_range(1, 3), c);
    for (int i = 0; i < n; i++) begin
      w = ld_q[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], $urandom_range(1, 3), c);
        if (b == 3) last_c.push_back(c);
      end
      exp_mem[i % 128] = w;
    end
    repeat (2) step();
    check("debug_flag_after_load", debug_flag, 0);
    check("busy_after_load", busy, 0);
    check("write_count", wr_cnt - wr0, n);
    for (int i = 0; i < n && i < wr_cyc_q.size(); i++)
      check("wea_timing", wr_cyc_q[i], last_c[i] + 1);
    for (int a = 0; a < n && a < 128; a++)
      check("mem_word", dut_mem[a], exp_mem[a]);
    if (n > 0) check("word_held", out_ins_to_mem, ld_q[n-1]);
  endtask

  // act as the UART: acknowledge each byte after a random delay
  task automatic serve_dump(input bit poke);
    int t;
    for (int k = 0; k < NBYTES; k++) begin
      t = 0;
      while (tx_start !== 1'b1 && t < 64) begin
        step();
        t++;
      end
      check("tx_start_seen", tx_start, 1);
      if (tx_start !== 1'b1) return;
      if (k == 0) begin
        in_pc   = $urandom;
        in_regs = {8{$urandom}};
      end
      repeat ($urandom_range(0, 3)) step();
      step();
      tx_done = 1'b1;
      if (poke && k == 5) begin
        rx_data = CMD_LOAD;
        rx_done = 1'b1;
      end
      step();
      tx_done = 1'b0;
      rx_done = 1'b0;
      if (k < NBYTES - 1) check("tx_start_after_done", tx_start, 1);
      else                check("idle_after_last", busy, 0);
    end
    repeat (3) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    repeat (3) step();
    check("dump_len", tx_q.size(), NBYTES);
    check("debug_flag_after_dump", debug_flag, 0);
    check("busy_after_dump", busy, 0);
  endtask

  task automatic check_dump(input int en_cycles, input int h);
    logic [31:0] words [$];
    logic [7:0]  exp_b [$];
    words.push_back(m_pc);
    for (int i = 0; i < 8; i++) words.push_back(m_regs[i]);
`ifdef DBG_CYCLE_COUNT_EN
    words.push_back(en_cycles);
`endif
    foreach (words[i])
      for (int b = 0; b < 4; b++) exp_b.push_back(8'(words[i] >> (8*b)));
    check("cpu_en_cycles", en_cyc_q.size(), en_cycles);
    if (txs_cyc_q.size() > 0) check("first_tx_latency", txs_cyc_q[0], h + 2);
    for (int i = 0; i < exp_b.size() && i < tx_q.size(); i++)
      check("dump_byte", tx_q[i], exp_b[i]);
  endtask

  task automatic prep_dump();
    en_cyc_q.delete();
    tx_q.delete();
    txs_cyc_q.delete();
    drive_state();
  endtask

  task automatic do_step(input bit halted, input bit poke);
    int c;
    halt_flag = halted;
    prep_dump();
    send_byte(CMD_STEP, 0, c);
    check("busy_in_step", busy, 1);
    step();
    tx_done = 1'b1;  // nothing outstanding yet: must be ignored
    step();
    tx_done = 1'b0;
    serve_dump(poke);
    check_dump(halted ? 0 : 1, c + 1);
    if (!halted && en_cyc_q.size() > 0) check("step_en_cycle", en_cyc_q[0], c + 1);
    halt_flag = 1'b0;
  endtask

  task automatic do_run(input int k, input bit poke);
    int c, h;
    halt_flag = (k == 0);
    prep_dump();
    send_byte(CMD_CONT, 0, c);
    h = c + 1;
    if (k > 0) begin
      repeat (k) step();
      halt_flag = 1'b1;
      h = c + k + 1;
    end
    serve_dump(poke);
    check_dump(k, h);
    halt_flag = 1'b0;
  endtask

  initial begin
    int c;
    rst_n = 1'b0; rx_data = '0; rx_done = 1'b0; tx_done = 1'b0; halt_flag = 1'b0;
    m_pc = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    for (int a = 0; a < 128; a++) begin
      exp_mem[a] = '0;
      dut_mem[a] = '0;
    end
    drive_state();
    repeat (3) step();
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_debug_flag", debug_flag, 0);
    check("rst_addr", out_addr_mem, 0);
    check("rst_ins", out_ins_to_mem, 0);
    check("rst_wea", wea_ram_inst, 0);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // two-word load
    ld_q = {32'h12345678, 32'hDEADBEEF};
    do_load(2);
    check("mem0_literal", dut_mem[0], 32'h12345678);
    check("mem1_literal", dut_mem[1], 32'hDEADBEEF);

    // empty load, then an unknown command
    do_load(0);
    send_byte(8'h5A, 1, c);
    check("unknown_cmd_busy", busy, 0);
    check("unknown_cmd_dbg", debug_flag, 0);

    // single step with known PC / reg1
    m_pc = 32'h4;
    for (int i = 0; i < 8; i++) m_regs[i] = $urandom;
    m_regs[0] = '0;
    m_regs[1] = 32'h0A;
    do_step(1'b0, 1'b0);

    // continuous run halting after 10 cycles, then random variants
    m_pc = $urandom;
    do_run(10, 1'b0);
    for (int r = 0; r < 2; r++) begin
      m_pc = $urandom;
      for (int i = 0; i < 8; i++) m_regs[i] = $urandom;
      do_run($urandom_range(1, 20), 1'b0);
    end
    do_run(0, 1'b0);
    do_step(1'b1, 1'b0);

    // reset in the middle of a word
    send_byte(CMD_LOAD, 1, c);
    send_byte(8'd3, 1, c);
    send_byte(8'hAA, 1, c);
    send_byte(8'hBB, 1, c);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ins", out_ins_to_mem, 0);
    check("midrst_addr", out_addr_mem, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    ld_q = {$urandom};
    do_load(1);
    check("after_rst_write_addr0", dut_mem[0], ld_q[0]);

    // 129 words wrap onto address 0; rx during the following dump is dropped
    ld_q.delete();
    for (int i = 0; i < 129; i++) ld_q.push_back($urandom);
    do_load(129);
    check("wrap_mem0", dut_mem[0], ld_q[128]);
    check("wrap_mem1", dut_mem[1], ld_q[1]);
    m_pc = $urandom;
    for (int i = 0; i < 8; i++) m_regs[i] = $urandom;
    do_step(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
